dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the BeeF core (load/store via head and stack pointers) and a host port (program/data loader, I/O debug).
- The core has priority.
- A starvation counter forces a host grant after STARVE_LIMIT consecutive denied cycles.
- A lock mode lets the host own the port for burst loads while the core is stalled.
- Sits between the core datapath and the synchronous data memory. Memory read data is valid one cycle after the access.

Parameters:
- ADDR_W, 8, address width (matches BYTE head/stack pointers)
- DATA_W, 8, data width
- STARVE_LIMIT, 4, host denied cycles before a forced grant; legal range 1..15

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- core_req  input  1  core access request (level, held while stalled)
- core_we  input  1  1=write, 0=read
- core_addr  input  ADDR_W  core address
- core_wdata  input  DATA_W  core write data
- core_stall  output  1  core request not granted this cycle
- core_rvalid  output  1  core read data valid
- core_rdata  output  DATA_W  core read data
- host_req  input  1  host access request (held until host_ack)
- host_we  input  1  1=write, 0=read
- host_lock  input  1  request exclusive ownership
- host_addr  input  ADDR_W  host address
- host_wdata  input  DATA_W  host write data
- host_ack  output  1  host request granted this cycle
- host_rvalid  output  1  host read data valid
- host_rdata  output  DATA_W  host read data
- locked  output  1  arbiter in LOCKED state
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after a read

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ARB, starve_cnt=0, resp_tag=NONE.
  - core_rvalid=0, host_rvalid=0, host_ack=0, mem_en=0, locked=0.
  - core_stall=core_req.
  - Any in-flight read response is dropped.
- Grant decision is combinational in the current cycle; exactly one of gnt_core or gnt_host may be 1.
  - In ARB:
    - gnt_host = host_req & (!core_req | starve_cnt==STARVE_LIMIT)
    - gnt_core = core_req & !gnt_host
  - In LOCKED:
    - gnt_host = host_req
    - gnt_core = 0
- Memory port:
  - mem_en = gnt_core | gnt_host.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - All are 0 when there is no grant.
- host_ack = gnt_host.
- core_stall = core_req & !gnt_core.
- starve_cnt (registered, saturating at STARVE_LIMIT):
  - Increments each cycle host_req & !gnt_host.
  - Clears to 0 when gnt_host or !host_req.
- State machine:
  - ARB -> LOCKED at the edge where gnt_host & host_lock.
  - LOCKED -> ARB at the first edge where host_lock=0. The cycle in which host_lock falls is still host-owned.
  - LOCKED holds while host_lock=1, even with host_req=0; the port stays idle and the core stalls.
- Read response:
  - resp_tag registers CORE/HOST/NONE at each edge, for a granted read with we=0.
  - In the following cycle the tagged rvalid is 1 and the tagged rdata = mem_rdata.
  - rdata is don't-care when rvalid=0.
  - Back-to-back reads give one rvalid per cycle, in grant order.
- Writes complete at the grant edge; no response is generated.
- Simultaneous requests to the same address: only one is granted per cycle, so there is no hazard inside the arbiter. A host write followed by a core read of that address returns the new data.
- Reset mid-lock returns to ARB; the host must re-issue host_lock.

Test Plan:
- Reset, then core_req=1 read addr 8'h80 for 3 cycles, host idle -> core_stall=0 each cycle; mem_en=1, mem_addr=8'h80; core_rvalid=1 one cycle after each grant with core_rdata=mem_rdata.
- core_req=1 continuous, host_req=1 write addr 8'h05 data 8'h03, STARVE_LIMIT=4:
  - host_ack=0 for 4 cycles (starve_cnt 1..4).
  - 5th cycle: host_ack=1, core_stall=1, mem_we=1, mem_addr=8'h05.
  - Next cycle starve_cnt=0 and the core is regranted.
- host_req=1, host_lock=1, core idle:
  - Grant occurs, then locked=1.
  - Core then requests: core_stall=1 for all 6 locked cycles while host writes 6 bytes.
  - Drop host_lock -> locked=0 next edge; core granted the cycle after.
- Host write 8'hAA to addr 8'h10 granted, core read 8'h10 next cycle -> core_rvalid=1 with core_rdata=8'hAA.
- Host read granted at cycle N, reset asserted low at N+0.5 -> host_rvalid stays 0, locked=0, mem_en=0 while reset=0.
- Alternating core and host reads on consecutive cycles -> rvalid tags follow grant order, never both rvalid=1 in the same cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core has priority, host gets a forced grant after
// STARVE_LIMIT denied cycles, and can lock the port for burst transfers.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_HOST} tag_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state, w_state_nxt;
  tag_t       r_tag, w_tag_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       w_gnt_core, w_gnt_host, w_starved;

  // Grants are masked while reset is held so the port is idle during reset.
  always_comb begin
    w_gnt_host = 1'b0;
    w_gnt_core = 1'b0;
    w_starved  = (r_starve == LIMIT);
    if (reset) begin
      if (r_state == ST_LOCKED) begin
        w_gnt_host = host_req;
      end else begin
        w_gnt_host = host_req & (~core_req | w_starved);
        w_gnt_core = core_req & ~w_gnt_host;
      end
    end
  end

  always_comb begin
    mem_en    = w_gnt_core | w_gnt_host;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_host) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (w_gnt_core) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tag_nxt    = TAG_NONE;
    w_starve_nxt = '0;

    if (host_req & ~w_gnt_host)
      w_starve_nxt = w_starved ? r_starve : r_starve + 4'd1;

    case (r_state)
      ST_ARB:    if (w_gnt_host & host_lock) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (!host_lock)             w_state_nxt = ST_ARB;
      default:                               w_state_nxt = ST_ARB;
    endcase

    if (w_gnt_host & ~host_we)
      w_tag_nxt = TAG_HOST;
    else if (w_gnt_core & ~core_we)
      w_tag_nxt = TAG_CORE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_ARB;
      r_tag    <= TAG_NONE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tag    <= w_tag_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    host_ack    = w_gnt_host;
    core_stall  = core_req & ~w_gnt_core;
    locked      = (r_state == ST_LOCKED);
    core_rvalid = (r_tag == TAG_CORE);
    host_rvalid = (r_tag == TAG_HOST);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal checks plus a
// per-cycle reference model (shadow memory, pending-response tracking).
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic       clk, reset;
  logic       core_req, core_we, core_stall, core_rvalid;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_lock, host_ack, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       locked, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .locked(locked), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Synchronous data memory: write at the grant edge, read data one cycle later.
  logic [7:0] bmem [256];
  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = init_val(i);
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) bmem[mem_addr] <= mem_wdata;
        else        mem_rdata      <= bmem[mem_addr];
      end
    end
  end

  // Reference model
  logic       m_locked;
  int         m_starve;
  int         m_tag;       // 0 none, 1 core, 2 host
  logic [7:0] m_tag_data;
  logic [7:0] shadow [256];
  logic       e_hg, e_cg;
  logic [7:0] e_addr, e_wdata;
  logic       e_we;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_locked = 1'b0; m_starve = 0; m_tag = 0; m_tag_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_locked = 1'b0; m_starve = 0; m_tag = 0;
        chk1("m_rst_host_ack",    host_ack,    1'b0);
        chk1("m_rst_mem_en",      mem_en,      1'b0);
        chk1("m_rst_core_stall",  core_stall,  core_req);
        chk1("m_rst_locked",      locked,      1'b0);
        chk1("m_rst_core_rvalid", core_rvalid, 1'b0);
        chk1("m_rst_host_rvalid", host_rvalid, 1'b0);
      end else begin
        e_hg = host_req && (m_locked || !core_req || m_starve >= LIM);
        e_cg = core_req && !m_locked && !e_hg;
        e_addr  = e_hg ? host_addr  : (e_cg ? core_addr  : 8'h00);
        e_wdata = e_hg ? host_wdata : (e_cg ? core_wdata : 8'h00);
        e_we    = (e_hg && host_we) || (e_cg && core_we);
        chk1("m_host_ack",    host_ack,    e_hg);
        chk1("m_core_stall",  core_stall,  core_req && !e_cg);
        chk1("m_mem_en",      mem_en,      e_hg || e_cg);
        chk1("m_mem_we",      mem_we,      e_we);
        chk8("m_mem_addr",    mem_addr,    e_addr);
        chk8("m_mem_wdata",   mem_wdata,   e_wdata);
        chk1("m_locked",      locked,      m_locked);
        chk1("m_core_rvalid", core_rvalid, m_tag == 1);
        chk1("m_host_rvalid", host_rvalid, m_tag == 2);
        if (m_tag == 1) chk8("m_core_rdata", core_rdata, m_tag_data);
        if (m_tag == 2) chk8("m_host_rdata", host_rdata, m_tag_data);

        if (e_hg && host_we) shadow[host_addr] = host_wdata;
        if (e_cg && core_we) shadow[core_addr] = core_wdata;
        if (e_hg && !host_we) begin
          m_tag = 2; m_tag_data = shadow[host_addr];
        end else if (e_cg && !core_we) begin
          m_tag = 1; m_tag_data = shadow[core_addr];
        end else begin
          m_tag = 0;
        end
        if (host_req && !e_hg) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else                   m_starve = 0;
        m_locked = m_locked ? host_lock : (e_hg && host_lock);
      end
    end
  end

  task automatic drive_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic lock,
                            input logic [7:0] a, input logic [7:0] d);
    host_req = req; host_we = we; host_lock = lock; host_addr = a; host_wdata = d;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    drive_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    drive_core(1'b1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("rst_core_stall", core_stall, 1'b1);
    chk1("rst_mem_en",     mem_en,     1'b0);
    chk1("rst_locked",     locked,     1'b0);
    chk1("rst_host_ack",   host_ack,   1'b0);
    next_cycle; idle();
    next_cycle; reset = 1'b1;

    // Core-only reads
    drive_core(1'b1, 1'b0, 8'h80, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t1_core_stall", core_stall, 1'b0);
      chk1("t1_mem_en",     mem_en,     1'b1);
      chk8("t1_mem_addr",   mem_addr,   8'h80);
      chk1("t1_core_rvalid", core_rvalid, k > 0);
      if (k > 0) chk8("t1_core_rdata", core_rdata, 8'h25);
      next_cycle;
    end
    idle();
    @(negedge clk);
    chk1("t1_last_rvalid", core_rvalid, 1'b1);
    chk8("t1_last_rdata",  core_rdata,  8'h25);
    next_cycle;

    // Host starvation and forced grant
    drive_core(1'b1, 1'b0, 8'h20, 8'h00);
    drive_host(1'b1, 1'b1, 1'b0, 8'h05, 8'h03);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("t2_denied_ack",   host_ack,   1'b0);
      chk1("t2_denied_stall", core_stall, 1'b0);
      next_cycle;
    end
    @(negedge clk);
    chk1("t2_forced_ack",   host_ack,   1'b1);
    chk1("t2_forced_stall", core_stall, 1'b1);
    chk1("t2_forced_we",    mem_we,     1'b1);
    chk8("t2_forced_addr",  mem_addr,   8'h05);
    chk8("t2_forced_wdata", mem_wdata,  8'h03);
    next_cycle;
    @(negedge clk);
    chk1("t2_regrant_ack",   host_ack,   1'b0);
    chk1("t2_regrant_stall", core_stall, 1'b0);
    next_cycle;
    idle(); next_cycle;

    // Lock: host owns the port for a burst while the core stalls
    drive_host(1'b1, 1'b1, 1'b1, 8'h40, 8'h10);
    @(negedge clk);
    chk1("t3_grant_ack",    host_ack, 1'b1);
    chk1("t3_grant_locked", locked,   1'b0);
    next_cycle;
    drive_core(1'b1, 1'b0, 8'h41, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      drive_host(1'b1, 1'b1, k < 6, 8'(8'h40 + k), 8'(8'h10 + k));
      @(negedge clk);
      chk1("t3_locked",     locked,     1'b1);
      chk1("t3_core_stall", core_stall, 1'b1);
      chk1("t3_host_ack",   host_ack,   1'b1);
      next_cycle;
    end
    drive_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("t3_unlocked",   locked,     1'b0);
    chk1("t3_core_grant", core_stall, 1'b0);
    chk8("t3_core_addr",  mem_addr,   8'h41);
    next_cycle;
    idle();
    @(negedge clk);
    chk1("t3_core_rvalid", core_rvalid, 1'b1);
    chk8("t3_core_rdata",  core_rdata,  8'h11);
    next_cycle;

    // Host write then core read of the same address
    drive_host(1'b1, 1'b1, 1'b0, 8'h10, 8'hAA);
    @(negedge clk);
    chk1("t4_host_ack", host_ack, 1'b1);
    next_cycle;
    idle();
    drive_core(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk1("t4_core_stall", core_stall, 1'b0);
    next_cycle;
    idle();
    @(negedge clk);
    chk1("t4_core_rvalid", core_rvalid, 1'b1);
    chk8("t4_core_rdata",  core_rdata,  8'hAA);
    next_cycle;

    // Reset mid-lock drops the in-flight host read
    drive_host(1'b1, 1'b0, 1'b1, 8'h33, 8'h00);
    @(negedge clk);
    chk1("t5_first_ack", host_ack, 1'b1);
    next_cycle;
    drive_host(1'b1, 1'b0, 1'b1, 8'h34, 8'h00);
    drive_core(1'b1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("t5_locked",      locked,      1'b1);
    chk1("t5_ack",         host_ack,    1'b1);
    chk1("t5_host_rvalid", host_rvalid, 1'b1);
    chk8("t5_host_rdata",  host_rdata,  8'h96);
    #2 reset = 1'b0;
    #1;
    chk1("t5_async_locked", locked, 1'b0);
    chk1("t5_async_mem_en", mem_en, 1'b0);
    next_cycle;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("t5_rst_host_rvalid", host_rvalid, 1'b0);
      chk1("t5_rst_locked",      locked,      1'b0);
      chk1("t5_rst_mem_en",      mem_en,      1'b0);
      chk1("t5_rst_core_stall",  core_stall,  1'b1);
      next_cycle;
    end
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk1("t5_post_locked", locked,      1'b0);
    chk1("t5_post_rvalid", host_rvalid, 1'b0);
    next_cycle;

    // Alternating core and host reads
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        drive_core(1'b1, 1'b0, 8'(8'h60 + k), 8'h00);
        drive_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end else begin
        drive_core(1'b0, 1'b0, 8'h00, 8'h00);
        drive_host(1'b1, 1'b0, 1'b0, 8'(8'h60 + k), 8'h00);
      end
      @(negedge clk);
      chk1("t6_exclusive", core_rvalid & host_rvalid, 1'b0);
      if (k > 0) begin
        chk1("t6_core_rvalid", core_rvalid, (k % 2) == 1);
        chk1("t6_host_rvalid", host_rvalid, (k % 2) == 0);
        chk8("t6_rdata", (k % 2) == 1 ? core_rdata : host_rdata, init_val(8'h60 + k - 1));
      end
      next_cycle;
    end
    idle();
    @(negedge clk);
    chk1("t6_last_host_rvalid", host_rvalid, 1'b1);
    chk8("t6_last_host_rdata",  host_rdata,  8'hC0);
    next_cycle;

    // Locked with host idle: port stays idle, core stalls
    drive_host(1'b1, 1'b1, 1'b1, 8'h70, 8'h01);
    next_cycle;
    drive_host(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    drive_core(1'b1, 1'b0, 8'h70, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("t7_idle_mem_en", mem_en,     1'b0);
      chk1("t7_idle_stall",  core_stall, 1'b1);
      next_cycle;
    end
    host_lock = 1'b0;
    @(negedge clk);
    chk1("t7_fall_locked", locked,     1'b1);
    chk1("t7_fall_stall",  core_stall, 1'b1);
    next_cycle;
    @(negedge clk);
    chk1("t7_after_stall", core_stall, 1'b0);
    next_cycle;
    idle();
    next_cycle;
    @(negedge clk);
    chk1("t7_core_rvalid", core_rvalid, 1'b0);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
